// File: rtl/adc_pkg.sv
// Shared types and helpers for the serial ADC receiver.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_SHIFT,
    ST_DONE
  } adc_state_e;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/adc_clk_gen.sv
// adc_clk divider: toggles adc_clk every CLK_DIV cycles while running and
// flags the cycle in which each rising or falling toggle is about to happen.
module adc_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_adc_clk,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_adc_clk;
  logic             w_tc;

  assign w_tc      = i_run && (r_cnt == CNT_W'(CLK_DIV - 1));
  assign o_rise    = w_tc && !r_adc_clk;
  assign o_fall    = w_tc && r_adc_clk;
  assign o_adc_clk = r_adc_clk;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_adc_clk <= 1'b0;
    end else if (!i_run) begin
      r_cnt     <= '0;
      r_adc_clk <= 1'b0;
    end else if (w_tc) begin
      r_cnt     <= '0;
      r_adc_clk <= ~r_adc_clk;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_serial_rx.sv
// Serial ADC front end: conversion sequencing, frame capture and valid/ready output.
// Optional output o_overrun is built when ADC_OVERRUN_EN is defined.
module adc_serial_rx
  import adc_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16,
  parameter int MSB_POS    = 13,
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 1
) (
  input  logic                        i_osc_clk,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic                        i_single,
  input  logic                        i_adc_data,
  output logic                        o_adc_clk,
  output logic                        o_adc_conv,
  output logic [ch_width(NUM_CH)-1:0] o_adc_ch,
  output logic                        o_busy,
  output logic                        o_data_valid,
  input  logic                        i_data_ready,
  output logic [DATA_W-1:0]           o_data_out,
  output logic [ch_width(NUM_CH)-1:0] o_data_ch
`ifdef ADC_OVERRUN_EN
  ,
  output logic                        o_overrun
`endif
);

  localparam int CH_W      = ch_width(NUM_CH);
  localparam int BIT_W     = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int REL_W     = BIT_W + 1;
  localparam int FIRST_BIT = FRAME_BITS - 1 - MSB_POS;

  generate
    if (MSB_POS > FRAME_BITS - 1 || MSB_POS < DATA_W - 1 || CLK_DIV < 1) begin : g_bad_cfg
      $fatal(1, "adc_serial_rx: illegal CLK_DIV/FRAME_BITS/MSB_POS/DATA_W combination");
    end
  endgenerate

  adc_state_e        r_state;
  logic              r_adc_conv;
  logic              r_busy;
  logic [CH_W-1:0]   r_adc_ch;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_sr;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CH_W-1:0]   r_data_ch;

  logic              w_run;
  logic              w_rise;
  logic              w_fall;
  logic              w_load;
  logic              w_handshake;
  logic              w_capture;
  logic [REL_W-1:0]  w_rel;
  logic [CH_W-1:0]   w_ch_next;

  assign w_run       = (r_state == ST_CONV) || (r_state == ST_SHIFT);
  assign w_load      = (r_state == ST_DONE);
  assign w_handshake = r_valid && i_data_ready;
  assign w_ch_next   = (r_adc_ch == CH_W'(NUM_CH - 1)) ? '0 : r_adc_ch + 1'b1;

  // Only the bits of the data field are kept: at rise k the bit counter equals k,
  // and the field occupies rises FIRST_BIT .. FIRST_BIT+DATA_W-1 (wraps below).
  assign w_rel     = {1'b0, r_bit_cnt} - REL_W'(FIRST_BIT);
  assign w_capture = w_rise && (w_rel < REL_W'(DATA_W));

  adc_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .i_clk    (i_osc_clk),
    .i_rst    (i_reset),
    .i_run    (w_run),
    .o_adc_clk(o_adc_clk),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  always_ff @(posedge i_osc_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_adc_conv <= 1'b1;
      r_busy     <= 1'b0;
      r_adc_ch   <= '0;
      r_bit_cnt  <= '0;
      r_sr       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_enable || i_single) begin
            r_state <= ST_CONV;
            r_busy  <= 1'b1;
          end
        end
        ST_CONV: begin
          if (w_fall) begin
            r_state    <= ST_SHIFT;
            r_adc_conv <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (w_capture) begin
            r_sr <= DATA_W'({r_sr, i_adc_data});
          end
          if (w_fall) begin
            if (r_bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
              r_state    <= ST_DONE;
              r_adc_conv <= 1'b1;
              r_bit_cnt  <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_adc_ch <= w_ch_next;
          if (i_enable) begin
            r_state <= ST_CONV;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Newest sample always wins; the conversion engine never waits for the consumer.
  always_ff @(posedge i_osc_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_data_ch <= '0;
    end else if (w_load) begin
      r_valid   <= 1'b1;
      r_data    <= r_sr;
      r_data_ch <= r_adc_ch;
    end else if (w_handshake) begin
      r_valid <= 1'b0;
    end
  end

`ifdef ADC_OVERRUN_EN
  logic r_overrun;

  always_ff @(posedge i_osc_clk or posedge i_reset) begin
    if (i_reset) begin
      r_overrun <= 1'b0;
    end else if (w_load && r_valid && !i_data_ready) begin
      r_overrun <= 1'b1;
    end else if (w_handshake) begin
      r_overrun <= 1'b0;
    end
  end

  assign o_overrun = r_overrun;
`endif

  assign o_adc_conv   = r_adc_conv;
  assign o_adc_ch     = r_adc_ch;
  assign o_busy       = r_busy;
  assign o_data_valid = r_valid;
  assign o_data_out   = r_data;
  assign o_data_ch    = r_data_ch;

endmodule

// File: tb/tb_adc_serial_rx.sv
// Bench for adc_serial_rx: a default-geometry 4-channel instance and a fast 12-bit instance,
// each fed by a behavioural serial ADC that shifts a frame out MSB first.
`timescale 1ns/1ps
module tb_adc_serial_rx;

  localparam int A_DIV = 4, A_FB = 16, A_MSB = 13, A_DW = 8, A_NCH = 4;
  localparam int B_DIV = 1, B_FB = 12, B_MSB = 11, B_DW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en_a = 1'b0, single_a = 1'b0, data_a = 1'b0, ready_a = 1'b0;
  logic        aclk_a, conv_a, busy_a, valid_a;
  logic [1:0]  ch_a, dch_a;
  logic [7:0]  dout_a;
  logic        en_b = 1'b0, single_b = 1'b0, data_b = 1'b0, ready_b = 1'b0;
  logic        aclk_b, conv_b, busy_b, valid_b;
  logic [0:0]  ch_b, dch_b;
  logic [11:0] dout_b;
`ifdef ADC_OVERRUN_EN
  logic        ovr_a, ovr_b;
`endif

  adc_serial_rx #(.CLK_DIV(A_DIV), .FRAME_BITS(A_FB), .MSB_POS(A_MSB), .DATA_W(A_DW), .NUM_CH(A_NCH)) u_a (
    .i_osc_clk(clk), .i_reset(rst), .i_enable(en_a), .i_single(single_a), .i_adc_data(data_a),
    .o_adc_clk(aclk_a), .o_adc_conv(conv_a), .o_adc_ch(ch_a), .o_busy(busy_a),
    .o_data_valid(valid_a), .i_data_ready(ready_a), .o_data_out(dout_a), .o_data_ch(dch_a)
`ifdef ADC_OVERRUN_EN
    , .o_overrun(ovr_a)
`endif
  );

  adc_serial_rx #(.CLK_DIV(B_DIV), .FRAME_BITS(B_FB), .MSB_POS(B_MSB), .DATA_W(B_DW), .NUM_CH(1)) u_b (
    .i_osc_clk(clk), .i_reset(rst), .i_enable(en_b), .i_single(single_b), .i_adc_data(data_b),
    .o_adc_clk(aclk_b), .o_adc_conv(conv_b), .o_adc_ch(ch_b), .o_busy(busy_b),
    .o_data_valid(valid_b), .i_data_ready(ready_b), .o_data_out(dout_b), .o_data_ch(dch_b)
`ifdef ADC_OVERRUN_EN
    , .o_overrun(ovr_b)
`endif
  );

  // Behavioural ADC A: latches the next frame when conv falls, shifts on each adc_clk fall.
  logic [15:0] fr_a [64];
  logic [15:0] cur_a = '0;
  int          fcnt_a = 0, idx_a = A_FB - 1, rise_a = 0, convlow_a = 0, chglitch_a = 0;
  logic        pconv_a = 1'b1, pclk_a = 1'b0;
  logic [1:0]  pch_a = '0;

  always @(negedge clk) begin
    if (conv_a) idx_a = A_FB - 1;
    else if (pconv_a) begin cur_a = fr_a[fcnt_a % 64]; fcnt_a++; idx_a = A_FB - 1; end
    else if (pclk_a && !aclk_a && idx_a > 0) idx_a--;
    data_a = cur_a[idx_a];
    if (!conv_a) begin
      convlow_a++;
      if (!pclk_a && aclk_a) rise_a++;
      if (!pconv_a && ch_a != pch_a) chglitch_a++;
    end
    pconv_a = conv_a; pclk_a = aclk_a; pch_a = ch_a;
  end

  logic [11:0] fr_b [64];
  logic [11:0] cur_b = '0;
  int          fcnt_b = 0, idx_b = B_FB - 1, notog_b = 0;
  logic        pconv_b = 1'b1, pclk_b = 1'b0;

  always @(negedge clk) begin
    if (conv_b) idx_b = B_FB - 1;
    else if (pconv_b) begin cur_b = fr_b[fcnt_b % 64]; fcnt_b++; idx_b = B_FB - 1; end
    else if (pclk_b && !aclk_b && idx_b > 0) idx_b--;
    data_b = cur_b[idx_b];
    if (!conv_b && !pconv_b && aclk_b == pclk_b) notog_b++;
    pconv_b = conv_b; pclk_b = aclk_b;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] field(input logic [31:0] frame, input int msb, input int dw);
    return (frame >> (msb - dw + 1)) & ((32'd1 << dw) - 32'd1);
  endfunction

  function automatic int latency(input int div, input int fb);
    return 2 * div * (fb + 1) + 1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid_a(input string tag, output int n);
    n = 0;
    while (!valid_a && n < 2000) begin step(1); n++; end
    chk({tag, "_valid_timeout"}, 32'(valid_a), 1);
  endtask

  task automatic wait_valid_b(input string tag, output int n);
    n = 0;
    while (!valid_b && n < 2000) begin step(1); n++; end
    chk({tag, "_valid_timeout"}, 32'(valid_b), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, n2, c, chn, base, r0, l0;
    logic [15:0] f;
    for (int i = 0; i < 64; i++) begin fr_a[i] = 16'($urandom); fr_b[i] = 12'($urandom); end

    step(3);
    chk("rst_adc_clk", 32'(aclk_a), 0);
    chk("rst_adc_conv", 32'(conv_a), 1);
    chk("rst_adc_ch", 32'(ch_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_data_valid", 32'(valid_a), 0);
    chk("rst_data_out", 32'(dout_a), 0);
    chk("rst_data_ch", 32'(dch_a), 0);
    chk("rst_b_conv", 32'(conv_b), 1);
    chk("rst_b_valid", 32'(valid_b), 0);
`ifdef ADC_OVERRUN_EN
    chk("rst_overrun", 32'(ovr_a | ovr_b), 0);
`endif
    rst = 1'b0;
    step(2);
    chn = 0;

    // one-shot conversion, latency and hold while not ready
    fr_a[fcnt_a % 64] = 16'h1FE0;
    single_a = 1'b1; step(1); single_a = 1'b0;
    wait_valid_a("t1", n);
    chk("t1_latency", n, latency(A_DIV, A_FB));
    chk("t1_data_out", 32'(dout_a), field(32'h1FE0, A_MSB, A_DW));
    chk("t1_data_ch", 32'(dch_a), chn); chn = (chn + 1) % A_NCH;
    chk("t1_busy_after", 32'(busy_a), 0);
    chk("t1_conv_after", 32'(conv_a), 1);
    step(5);
    chk("t1_valid_held", 32'(valid_a), 1);
    ready_a = 1'b1; step(1); ready_a = 1'b0;
    chk("t1_handshake_clears", 32'(valid_a), 0);

    // field extraction, strobe count, conv-low width, single while busy ignored
    f = 16'b00_10110011_000000;
    fr_a[fcnt_a % 64] = f;
    r0 = rise_a; l0 = convlow_a; ready_a = 1'b1;
    single_a = 1'b1; step(1); single_a = 1'b0;
    step(40);
    single_a = 1'b1; step(1); single_a = 1'b0;
    wait_valid_a("t2", n2);
    chk("t2_latency", n2 + 41, latency(A_DIV, A_FB));
    chk("t2_data_out_b3", 32'(dout_a), 32'hB3);
    chk("t2_data_out_model", 32'(dout_a), field(32'(f), A_MSB, A_DW));
    chk("t2_data_ch", 32'(dch_a), chn); chn = (chn + 1) % A_NCH;
    chk("t2_rise_strobes", rise_a - r0, A_FB);
    chk("t2_conv_low_cycles", convlow_a - l0, 2 * A_DIV * A_FB);
    step(1);
    chk("t2_ready_clears", 32'(valid_a), 0);
    step(20);
    chk("t2_single_ignored", 32'(busy_a), 0);

    // continuous round robin, then enable dropped mid-frame
    base = fcnt_a;
    en_a = 1'b1; step(1);
    for (int k = 0; k < 5; k++) begin
      wait_valid_a("t3", n);
      chk("t3_gap", (k == 0) ? n : n + 1, latency(A_DIV, A_FB));
      chk("t3_data_out", 32'(dout_a), field(32'(fr_a[(base + k) % 64]), A_MSB, A_DW));
      chk("t3_data_ch", 32'(dch_a), chn);
      chk("t3_adc_ch_next", 32'(ch_a), (chn + 1) % A_NCH);
      chn = (chn + 1) % A_NCH;
      step(1);
    end
    step(60);
    en_a = 1'b0;
    wait_valid_a("t3_stop", n);
    chk("t3_stop_data_out", 32'(dout_a), field(32'(fr_a[(base + 5) % 64]), A_MSB, A_DW));
    chk("t3_stop_data_ch", 32'(dch_a), chn); chn = (chn + 1) % A_NCH;
    chk("t3_stop_busy", 32'(busy_a), 0);
    c = 0;
    for (int i = 0; i < 200; i++) begin step(1); if (valid_a || busy_a) c++; end
    chk("t3_idle_after_stop", c, 0);
    chk("t3_adc_ch_stable", chglitch_a, 0);

    // back-pressure: overwrite, hold, load coincident with handshake
    ready_a = 1'b0;
    base = fcnt_a;
    fr_a[base % 64] = 16'(32'h11 << 6);
    fr_a[(base + 1) % 64] = 16'(32'h22 << 6);
    fr_a[(base + 2) % 64] = 16'h2D40;
    en_a = 1'b1; step(1);
    wait_valid_a("t4", n);
    chk("t4_first", 32'(dout_a), 32'h11); chn = (chn + 1) % A_NCH;
    step(latency(A_DIV, A_FB));
    chk("t4_valid_kept", 32'(valid_a), 1);
    chk("t4_newest_wins", 32'(dout_a), 32'h22);
    chk("t4_data_ch", 32'(dch_a), chn); chn = (chn + 1) % A_NCH;
`ifdef ADC_OVERRUN_EN
    chk("t4_overrun_set", 32'(ovr_a), 1);
`endif
    step(latency(A_DIV, A_FB) - 1);
    chk("t4_data_held", 32'(dout_a), 32'h22);
`ifdef ADC_OVERRUN_EN
    chk("t4_overrun_sticky", 32'(ovr_a), 1);
`endif
    ready_a = 1'b1; en_a = 1'b0; step(1);
    chk("t4_load_hs_valid", 32'(valid_a), 1);
    chk("t4_load_hs_data", 32'(dout_a), field(32'h2D40, A_MSB, A_DW));
    chk("t4_load_hs_ch", 32'(dch_a), chn); chn = (chn + 1) % A_NCH;
`ifdef ADC_OVERRUN_EN
    chk("t4_overrun_cleared", 32'(ovr_a), 0);
`endif
    step(1);
    chk("t4_final_hs", 32'(valid_a), 0);
    chk("t4_busy_idle", 32'(busy_a), 0);
    ready_a = 1'b0;
    // leave a sample pending so the reset has something to clear
    single_a = 1'b1; step(1); single_a = 1'b0;
    wait_valid_a("t4_pend", n);
    chn = (chn + 1) % A_NCH;

    // reset during the shift phase aborts everything at once
    single_a = 1'b1; step(1); single_a = 1'b0;
    step(2 * A_DIV + 2 * A_DIV * 8 + 3);
    chk("t5_pre_conv_low", 32'(conv_a), 0);
    #2 rst = 1'b1;
    #1;
    chk("t5_adc_clk", 32'(aclk_a), 0);
    chk("t5_adc_conv", 32'(conv_a), 1);
    chk("t5_adc_ch", 32'(ch_a), 0);
    chk("t5_busy", 32'(busy_a), 0);
    chk("t5_data_valid", 32'(valid_a), 0);
    chk("t5_data_out", 32'(dout_a), 0);
    chk("t5_data_ch", 32'(dch_a), 0);
    step(3);
    rst = 1'b0;
    c = 0;
    for (int i = 0; i < 300; i++) begin step(1); if (valid_a || busy_a) c++; end
    chk("t5_idle_after_reset", c, 0);
    base = fcnt_a;
    single_a = 1'b1; step(1); single_a = 1'b0;
    wait_valid_a("t5_restart", n);
    chk("t5_restart_latency", n, latency(A_DIV, A_FB));
    chk("t5_restart_data", 32'(dout_a), field(32'(fr_a[base % 64]), A_MSB, A_DW));
    chk("t5_restart_ch", 32'(dch_a), 0);

    // fast divider, full-width word
    fr_b[fcnt_b % 64] = 12'hA5C;
    single_b = 1'b1; step(1); single_b = 1'b0;
    wait_valid_b("t6", n);
    chk("t6_latency", n, latency(B_DIV, B_FB));
    chk("t6_data_out", 32'(dout_b), 32'hA5C);
    chk("t6_data_ch", 32'(dch_b), 0);
    chk("t6_toggle_every_cycle", notog_b, 0);
    ready_b = 1'b1; step(1);
    chk("t6_handshake_clears", 32'(valid_b), 0);
    base = fcnt_b;
    single_b = 1'b1; step(1); single_b = 1'b0;
    wait_valid_b("t6_rand", n);
    chk("t6_rand_data", 32'(dout_b), field(32'(fr_b[base % 64]), B_MSB, B_DW));
    chk("t6_rand_latency", n, latency(B_DIV, B_FB));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
